// File: rtl/hbbus_pkg.sv
// Shared definitions for the hbarbiter slice: default word width, arbiter
// state encoding (doubles as the o_owner code) and requester identifiers.
package hbbus_pkg;

  localparam int unsigned HB_W = 34;

  localparam logic [1:0] OWNER_NONE = 2'b00;
  localparam logic [1:0] OWNER_A    = 2'b01;
  localparam logic [1:0] OWNER_B    = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE    = OWNER_NONE,
    ST_GRANT_A = OWNER_A,
    ST_GRANT_B = OWNER_B
  } arb_state_e;

  typedef enum logic {
    SRC_A = 1'b0,
    SRC_B = 1'b1
  } src_e;

endpackage

// File: rtl/hbarbiter_if.sv
// Handshake bundle between two requesters, the arbiter and the downstream sink.
// slave: the arbiter's view; master: the environment driving requests and stall.
interface hbarbiter_if
  import hbbus_pkg::*;
#(
  parameter int unsigned W = HB_W
) ();

  logic         i_a_stb;
  logic [W-1:0] i_a_word;
  logic         i_a_last;
  logic         o_a_busy;

  logic         i_b_stb;
  logic [W-1:0] i_b_word;
  logic         i_b_last;
  logic         o_b_busy;

  logic         o_stb;
  logic [W-1:0] o_word;
  logic         i_busy;
  logic [1:0]   o_owner;

  modport slave (
    input  i_a_stb, i_a_word, i_a_last,
    input  i_b_stb, i_b_word, i_b_last,
    input  i_busy,
    output o_a_busy, o_b_busy,
    output o_stb, o_word, o_owner
  );

  modport master (
    output i_a_stb, i_a_word, i_a_last,
    output i_b_stb, i_b_word, i_b_last,
    output i_busy,
    input  o_a_busy, o_b_busy,
    input  o_stb, o_word, o_owner
  );

endinterface

// File: rtl/hbarb_oreg.sv
// Output word register: loads on accept, holds o_stb/o_word while the sink
// stalls, and drops o_stb once the word has been taken with nothing new.
module hbarb_oreg #(
  parameter int unsigned W = 34
) (
  input  logic         i_clk,
  input  logic         i_reset_n,
  input  logic         i_load,
  input  logic [W-1:0] i_word,
  input  logic         i_busy,
  output logic         o_stb,
  output logic [W-1:0] o_word
);

  logic         stb_d,  stb_q;
  logic [W-1:0] word_d, word_q;

  // A load never coincides with a stall: the arbiter only accepts when !(o_stb && i_busy).
  always_comb begin
    stb_d  = stb_q;
    word_d = word_q;
    if (i_load) begin
      stb_d  = 1'b1;
      word_d = i_word;
    end else if (!(stb_q && i_busy)) begin
      stb_d  = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      stb_q  <= 1'b0;
      word_q <= '0;
    end else begin
      stb_q  <= stb_d;
      word_q <= word_d;
    end
  end

  assign o_stb  = stb_q;
  assign o_word = word_q;

endmodule

// File: rtl/hbarbiter.sv
// Two-requester packet arbiter; grant holds for a whole packet.
// Define HBARB_ROUND_ROBIN_EN for round-robin tie-break, otherwise A has fixed priority.
module hbarbiter
  import hbbus_pkg::*;
#(
  parameter int unsigned W = HB_W
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  hbarbiter_if.slave  bus
);

  arb_state_e   state_d, state_q;
  logic         stall;
  logic         a_busy, b_busy;
  logic         a_acc,  b_acc;
  logic         acc;
  logic [W-1:0] acc_word;
  logic         oreg_stb;
  logic [W-1:0] oreg_word;

`ifdef HBARB_ROUND_ROBIN_EN
  src_e last_d, last_q;
`endif

  always_comb begin
    stall  = oreg_stb && bus.i_busy;
    a_busy = 1'b1;
    b_busy = 1'b1;
    case (state_q)
      ST_GRANT_A: a_busy = stall;
      ST_GRANT_B: b_busy = stall;
      default: ;
    endcase

    a_acc    = (state_q == ST_GRANT_A) && bus.i_a_stb && !a_busy;
    b_acc    = (state_q == ST_GRANT_B) && bus.i_b_stb && !b_busy;
    acc      = a_acc || b_acc;
    acc_word = (state_q == ST_GRANT_B) ? bus.i_b_word : bus.i_a_word;

    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
`ifdef HBARB_ROUND_ROBIN_EN
        if (bus.i_a_stb && (!bus.i_b_stb || last_q == SRC_B))
          state_d = ST_GRANT_A;
        else if (bus.i_b_stb)
          state_d = ST_GRANT_B;
`else
        if (bus.i_a_stb)
          state_d = ST_GRANT_A;
        else if (bus.i_b_stb)
          state_d = ST_GRANT_B;
`endif
      end
      ST_GRANT_A: if (a_acc && bus.i_a_last) state_d = ST_IDLE;
      ST_GRANT_B: if (b_acc && bus.i_b_last) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase

`ifdef HBARB_ROUND_ROBIN_EN
    last_d = last_q;
    if (a_acc && bus.i_a_last)
      last_d = SRC_A;
    else if (b_acc && bus.i_b_last)
      last_d = SRC_B;
`endif
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= ST_IDLE;
`ifdef HBARB_ROUND_ROBIN_EN
      last_q  <= SRC_B;
`endif
    end else begin
      state_q <= state_d;
`ifdef HBARB_ROUND_ROBIN_EN
      last_q  <= last_d;
`endif
    end
  end

  hbarb_oreg #(
    .W (W)
  ) u_oreg (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_load    (acc),
    .i_word    (acc_word),
    .i_busy    (bus.i_busy),
    .o_stb     (oreg_stb),
    .o_word    (oreg_word)
  );

  assign bus.o_a_busy = a_busy;
  assign bus.o_b_busy = b_busy;
  assign bus.o_stb    = oreg_stb;
  assign bus.o_word   = oreg_word;
  assign bus.o_owner  = state_q;

endmodule

// File: tb/tb_hbarbiter.sv
// Directed bench for hbarbiter: streaming, stall hold, mid-packet contention,
// reset abandonment and tie-break (expectations follow HBARB_ROUND_ROBIN_EN).
module tb_hbarbiter;

  localparam int unsigned W = 34;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  hbarbiter_if #(.W(W)) bus ();

  hbarbiter #(
    .W (W)
  ) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic stb, input logic [W-1:0] word,
                         input logic [1:0] owner);
    chk({tag, "_stb"}, {63'd0, bus.o_stb}, {63'd0, stb});
    if (stb) chk({tag, "_word"}, {30'd0, bus.o_word}, {30'd0, word});
    chk({tag, "_owner"}, {62'd0, bus.o_owner}, {62'd0, owner});
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    bus.i_a_stb = 1'b0; bus.i_a_word = '0; bus.i_a_last = 1'b0;
    bus.i_b_stb = 1'b0; bus.i_b_word = '0; bus.i_b_last = 1'b0;
    bus.i_busy  = 1'b0;

    // Reset state
    #12;
    chk_out("rst", 1'b0, '0, 2'b00);
    chk("rst_abusy", {63'd0, bus.o_a_busy}, 64'd1);
    chk("rst_bbusy", {63'd0, bus.o_b_busy}, 64'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // A streams 3 words with no stall
    bus.i_a_stb = 1'b1; bus.i_a_word = 34'h1; bus.i_a_last = 1'b0;
    tick();
    chk_out("s_grant", 1'b0, '0, 2'b01);
    chk("s_abusy0", {63'd0, bus.o_a_busy}, 64'd0);
    chk("s_bbusy0", {63'd0, bus.o_b_busy}, 64'd1);
    tick();
    chk_out("s_w1", 1'b1, 34'h1, 2'b01);
    bus.i_a_word = 34'h2;
    tick();
    chk_out("s_w2", 1'b1, 34'h2, 2'b01);
    bus.i_a_word = 34'h3; bus.i_a_last = 1'b1;
    tick();
    chk_out("s_w3", 1'b1, 34'h3, 2'b00);
    bus.i_a_stb = 1'b0; bus.i_a_last = 1'b0;
    tick();
    chk_out("s_drain", 1'b0, '0, 2'b00);

    // Stall hold for 5 cycles
    bus.i_a_stb = 1'b1; bus.i_a_word = 34'h2AA;
    tick();
    chk_out("h_grant", 1'b0, '0, 2'b01);
    tick();
    chk_out("h_first", 1'b1, 34'h2AA, 2'b01);
    bus.i_busy = 1'b1; bus.i_a_word = 34'h155; bus.i_a_last = 1'b1;
    #1;
    chk("h_abusy_on", {63'd0, bus.o_a_busy}, 64'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_out("h_hold", 1'b1, 34'h2AA, 2'b01);
      chk("h_abusy", {63'd0, bus.o_a_busy}, 64'd1);
    end
    bus.i_busy = 1'b0;
    #1;
    chk("h_abusy_off", {63'd0, bus.o_a_busy}, 64'd0);
    tick();
    chk_out("h_next", 1'b1, 34'h155, 2'b00);
    bus.i_a_stb = 1'b0; bus.i_a_last = 1'b0;
    tick();
    chk_out("h_drain", 1'b0, '0, 2'b00);

    // B contends mid-packet of a 4-word A packet
    bus.i_a_stb = 1'b1; bus.i_a_word = 34'h10;
    tick();
    chk_out("m_grant", 1'b0, '0, 2'b01);
    tick();
    chk_out("m_a0", 1'b1, 34'h10, 2'b01);
    bus.i_a_word = 34'h11;
    tick();
    chk_out("m_a1", 1'b1, 34'h11, 2'b01);
    bus.i_a_word = 34'h12;
    bus.i_b_stb = 1'b1; bus.i_b_word = 34'h3BB; bus.i_b_last = 1'b1;
    #1;
    chk("m_bbusy0", {63'd0, bus.o_b_busy}, 64'd1);
    tick();
    chk_out("m_a2", 1'b1, 34'h12, 2'b01);
    bus.i_a_word = 34'h13; bus.i_a_last = 1'b1;
    #1;
    chk("m_bbusy1", {63'd0, bus.o_b_busy}, 64'd1);
    tick();
    chk_out("m_a3", 1'b1, 34'h13, 2'b00);
    bus.i_a_stb = 1'b0; bus.i_a_last = 1'b0;
    #1;
    chk("m_bbusy2", {63'd0, bus.o_b_busy}, 64'd1);
    tick();
    chk_out("m_bgrant", 1'b0, '0, 2'b10);
    chk("m_bbusy3", {63'd0, bus.o_b_busy}, 64'd0);
    tick();
    chk_out("m_b0", 1'b1, 34'h3BB, 2'b00);
    bus.i_b_stb = 1'b0; bus.i_b_last = 1'b0;
    tick();
    chk_out("m_drain", 1'b0, '0, 2'b00);

    // Reset during GRANT_B with o_stb high
    bus.i_b_stb = 1'b1; bus.i_b_word = 34'h21;
    tick();
    chk_out("r_grant", 1'b0, '0, 2'b10);
    tick();
    chk_out("r_b0", 1'b1, 34'h21, 2'b10);
    bus.i_b_word = 34'h22;
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("r_async", 1'b0, '0, 2'b00);
    chk("r_abusy", {63'd0, bus.o_a_busy}, 64'd1);
    chk("r_bbusy", {63'd0, bus.o_b_busy}, 64'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Simultaneous 1-word requests after reset: A first in both builds
    bus.i_a_stb = 1'b1; bus.i_a_word = 34'hA1; bus.i_a_last = 1'b1;
    bus.i_b_stb = 1'b1; bus.i_b_word = 34'hB1; bus.i_b_last = 1'b1;
    tick();
    chk_out("t_g0", 1'b0, '0, 2'b01);
    tick();
    chk_out("t_a1", 1'b1, 34'hA1, 2'b00);
    bus.i_a_word = 34'hA2;
`ifdef HBARB_ROUND_ROBIN_EN
    tick();
    chk_out("t_g1", 1'b0, '0, 2'b10);
    tick();
    chk_out("t_b1", 1'b1, 34'hB1, 2'b00);
    bus.i_b_word = 34'hB2;
    tick();
    chk_out("t_g2", 1'b0, '0, 2'b01);
    tick();
    chk_out("t_a2", 1'b1, 34'hA2, 2'b00);
`else
    tick();
    chk_out("t_g1", 1'b0, '0, 2'b01);
    chk("t_bbusy", {63'd0, bus.o_b_busy}, 64'd1);
    tick();
    chk_out("t_a2", 1'b1, 34'hA2, 2'b00);
    bus.i_a_word = 34'hA3;
    tick();
    chk_out("t_g2", 1'b0, '0, 2'b01);
    tick();
    chk_out("t_a3", 1'b1, 34'hA3, 2'b00);
    bus.i_a_stb = 1'b0; bus.i_a_last = 1'b0;
    tick();
    chk_out("t_gb", 1'b0, '0, 2'b10);
    tick();
    chk_out("t_b1", 1'b1, 34'hB1, 2'b00);
`endif
    bus.i_a_stb = 1'b0; bus.i_b_stb = 1'b0;
    tick();
    chk_out("t_drain", 1'b0, '0, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
